instruction_fetch_unit: RTL and testbench

- Front end of the MIPS pipeline.
- Owns the program counter and drives the byte address into the instruction ROM. The ROM read is combinational and word-indexed internally.
- Captures the returned instruction word plus PC+4 into the IF/ID pipeline register.
- Applies stall, flush and redirect (branch, j/jal, jr) requests from the decode/hazard logic.

---
 rtl/instruction_fetch_unit_if.sv | 37 +++
 rtl/instruction_fetch_unit.sv | 92 +++++++++
 tb/tb_instruction_fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Bus between the fetch unit and its neighbours: the hazard/decode controls,
// the program ROM, and the IF/ID pipeline register outputs.
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  Stall;
  logic                  Flush;
  logic                  BranchTaken;
  logic [DATA_WIDTH-1:0] BranchTarget;
  logic                  Jump;
  logic [25:0]           JumpTarget;
  logic                  JumpReg;
  logic [DATA_WIDTH-1:0] JumpRegAddr;
  logic [DATA_WIDTH-1:0] InstrAddress;
  logic [DATA_WIDTH-1:0] Instruction;
  logic [DATA_WIDTH-1:0] PC;
  logic [DATA_WIDTH-1:0] IF_ID_Instruction;
  logic [DATA_WIDTH-1:0] IF_ID_PCPlus4;
  logic                  IF_ID_Valid;
  logic                  AddrError;

  // Driven by decode/hazard logic and the ROM.
  modport master (
    output Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget,
           JumpReg, JumpRegAddr, Instruction,
    input  InstrAddress, PC, IF_ID_Instruction, IF_ID_PCPlus4,
           IF_ID_Valid, AddrError
  );

  // The fetch unit itself.
  modport slave (
    input  Stall, Flush, BranchTaken, BranchTarget, Jump, JumpTarget,
           JumpReg, JumpRegAddr, Instruction,
    output InstrAddress, PC, IF_ID_Instruction, IF_ID_PCPlus4,
           IF_ID_Valid, AddrError
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// MIPS instruction fetch stage: program counter, next-PC selection with
// stall/redirect handling, and the IF/ID pipeline register.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE  = 32'h0040_0000
) (
  input logic                     clk,
  input logic                     reset,
  instruction_fetch_unit_if.slave bus
);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ifIdInstr_q, ifIdInstr_d;
  logic [DATA_WIDTH-1:0] ifIdPcPlus4_q, ifIdPcPlus4_d;
  logic                  ifIdValid_q, ifIdValid_d;
  logic                  addrError_q, addrError_d;

  logic [DATA_WIDTH-1:0] pcPlus4;
  logic [DATA_WIDTH-1:0] jumpAddr;
  logic [DATA_WIDTH-1:0] redirectTarget;
  logic                  redirect;

  assign pcPlus4  = pc_q + DATA_WIDTH'(4);
  // Region bits come from the jump's own PC+4, held in IF/ID, not the fetch PC.
  assign jumpAddr = {ifIdPcPlus4_q[DATA_WIDTH-1:28], bus.JumpTarget, 2'b00};

  always_comb begin
    redirect       = 1'b0;
    redirectTarget = '0;
    if (bus.JumpReg) begin
      redirect       = 1'b1;
      redirectTarget = bus.JumpRegAddr;
    end else if (bus.Jump) begin
      redirect       = 1'b1;
      redirectTarget = jumpAddr;
    end else if (bus.BranchTaken) begin
      redirect       = 1'b1;
      redirectTarget = bus.BranchTarget;
    end
  end

  always_comb begin
    pc_d          = pcPlus4;
    addrError_d   = addrError_q;
    ifIdInstr_d   = bus.Instruction;
    ifIdPcPlus4_d = pcPlus4;
    ifIdValid_d   = 1'b1;

    if (redirect) begin
      pc_d        = {redirectTarget[DATA_WIDTH-1:2], 2'b00};
      addrError_d = addrError_q | (|redirectTarget[1:0]);
    end else if (bus.Stall) begin
      pc_d = pc_q;
    end

    // A flush inserts a NOP bubble even when the pipe is stalled.
    if (bus.Flush) begin
      ifIdInstr_d   = '0;
      ifIdPcPlus4_d = '0;
      ifIdValid_d   = 1'b0;
    end else if (bus.Stall) begin
      ifIdInstr_d   = ifIdInstr_q;
      ifIdPcPlus4_d = ifIdPcPlus4_q;
      ifIdValid_d   = ifIdValid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      ifIdInstr_q   <= '0;
      ifIdPcPlus4_q <= '0;
      ifIdValid_q   <= 1'b0;
      addrError_q   <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      ifIdInstr_q   <= ifIdInstr_d;
      ifIdPcPlus4_q <= ifIdPcPlus4_d;
      ifIdValid_q   <= ifIdValid_d;
      addrError_q   <= addrError_d;
    end
  end

  assign bus.InstrAddress      = pc_q - TEXT_BASE;
  assign bus.PC                = pc_q;
  assign bus.IF_ID_Instruction = ifIdInstr_q;
  assign bus.IF_ID_PCPlus4     = ifIdPcPlus4_q;
  assign bus.IF_ID_Valid       = ifIdValid_q;
  assign bus.AddrError         = addrError_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed, table-driven bench for instruction_fetch_unit with a small
// combinational ROM model behind InstrAddress.
module tb_instruction_fetch_unit;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

  typedef struct {
    string       name;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br;
    logic [31:0] brTarget;
    logic        jmp;
    logic [25:0] jmpTarget;
    logic        jr;
    logic [31:0] jrAddr;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic [31:0] expPcPlus4;
    logic        expValid;
    logic        expErr;
  } vec_t;

  logic clk;
  logic reset;
  int   nApplied;
  int   nMiscompares;
  vec_t vecs[$];

  instruction_fetch_unit_if #(.DATA_WIDTH(32)) bus();

  instruction_fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (32'h0040_0000),
    .TEXT_BASE (32'h0040_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word 0/1 hold the test program; every other word encodes its index.
  function automatic logic [31:0] romWord(input logic [29:0] idx);
    if (idx == 30'd0) return 32'h2008_0005;
    if (idx == 30'd1) return 32'h2009_0003;
    return {16'hA000, idx[15:0]};
  endfunction

  assign bus.Instruction = romWord(bus.InstrAddress[31:2]);

  function automatic vec_t mk(input string name, input logic rst, input logic stall,
                              input logic flush, input logic br, input logic [31:0] brTarget,
                              input logic jmp, input logic [25:0] jmpTarget, input logic jr,
                              input logic [31:0] jrAddr, input logic [31:0] expPc,
                              input logic [31:0] expInstr, input logic [31:0] expPcPlus4,
                              input logic expValid, input logic expErr);
    vec_t v;
    v.name = name; v.rst = rst; v.stall = stall; v.flush = flush;
    v.br = br; v.brTarget = brTarget; v.jmp = jmp; v.jmpTarget = jmpTarget;
    v.jr = jr; v.jrAddr = jrAddr; v.expPc = expPc; v.expInstr = expInstr;
    v.expPcPlus4 = expPcPlus4; v.expValid = expValid; v.expErr = expErr;
    return v;
  endfunction

  task automatic compare(input string what, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", what, act, exp);
    end
  endtask

  // Drives one row's inputs and lets one rising edge happen.
  task automatic applyStimulus(input vec_t v);
    reset            = v.rst;
    bus.Stall        = v.stall;
    bus.Flush        = v.flush;
    bus.BranchTaken  = v.br;
    bus.BranchTarget = v.brTarget;
    bus.Jump         = v.jmp;
    bus.JumpTarget   = v.jmpTarget;
    bus.JumpReg      = v.jr;
    bus.JumpRegAddr  = v.jrAddr;
    @(posedge clk);
    #1;
    nApplied++;
  endtask

  task automatic checkOutput(input vec_t v);
    compare({v.name, ".PC"},           bus.PC,                v.expPc);
    compare({v.name, ".InstrAddress"}, bus.InstrAddress,      v.expPc - TEXT_BASE);
    compare({v.name, ".IF_ID_Instr"},  bus.IF_ID_Instruction, v.expInstr);
    compare({v.name, ".IF_ID_PC4"},    bus.IF_ID_PCPlus4,     v.expPcPlus4);
    compare({v.name, ".IF_ID_Valid"},  {31'd0, bus.IF_ID_Valid}, {31'd0, v.expValid});
    compare({v.name, ".AddrError"},    {31'd0, bus.AddrError},   {31'd0, v.expErr});
  endtask

  initial begin
    nApplied     = 0;
    nMiscompares = 0;

    //           name         rst st fl br brTarget      j  jTarget        jr jrAddr        PC            Instr         PC+4          V  E
    vecs.push_back(mk("rst0",     1, 0, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h0040_0000, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk("rst1",     1, 0, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h0040_0000, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk("fetch0",   0, 0, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1, 0));
    vecs.push_back(mk("fetch1",   0, 0, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1, 0));
    vecs.push_back(mk("stallA",   0, 1, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1, 0));
    vecs.push_back(mk("stallB",   0, 1, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1, 0));
    vecs.push_back(mk("unstall",  0, 0, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h0040_000C, 32'hA000_0002, 32'h0040_000C, 1, 0));
    vecs.push_back(mk("brFlSt",   0, 1, 1, 1, 32'h0040_0020, 0, 26'h0,        0, 32'h0,         32'h0040_0020, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk("postBr",   0, 0, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h0040_0024, 32'hA000_0008, 32'h0040_0024, 1, 0));
    vecs.push_back(mk("free9",    0, 0, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h0040_0028, 32'hA000_0009, 32'h0040_0028, 1, 0));
    vecs.push_back(mk("jrAlign",  0, 0, 0, 0, 32'h0,         0, 26'h0,        1, 32'h0040_0010, 32'h0040_0010, 32'hA000_000A, 32'h0040_002C, 1, 0));
    vecs.push_back(mk("free4",    0, 0, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h0040_0014, 32'hA000_0004, 32'h0040_0014, 1, 0));
    vecs.push_back(mk("jmpOvrBr", 0, 0, 0, 1, 32'h0040_0080, 1, 26'h010_0010, 0, 32'h0,         32'h0040_0040, 32'hA000_0005, 32'h0040_0018, 1, 0));
    vecs.push_back(mk("jrMisal",  0, 1, 0, 0, 32'h0,         1, 26'h010_0010, 1, 32'h0040_0013, 32'h0040_0010, 32'hA000_0005, 32'h0040_0018, 1, 1));
    vecs.push_back(mk("rstMid",   1, 1, 0, 0, 32'h0,         0, 26'h0,        1, 32'h0040_0003, 32'h0040_0000, 32'h0,         32'h0,         0, 0));
    vecs.push_back(mk("jrTop",    0, 0, 0, 0, 32'h0,         0, 26'h0,        1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h2008_0005, 32'h0040_0004, 1, 0));
    vecs.push_back(mk("wrap",     0, 0, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h0000_0000, 32'hA000_FFFF, 32'h0000_0000, 1, 0));
    vecs.push_back(mk("jrHigh",   0, 0, 0, 0, 32'h0,         0, 26'h0,        1, 32'h1000_0000, 32'h1000_0000, 32'hA000_0000, 32'h0000_0004, 1, 0));
    vecs.push_back(mk("freeHigh", 0, 0, 0, 0, 32'h0,         0, 26'h0,        0, 32'h0,         32'h1000_0004, 32'hA000_0000, 32'h1000_0004, 1, 0));
    vecs.push_back(mk("jmpRegion",0, 0, 0, 0, 32'h0,         1, 26'h000_0004, 0, 32'h0,         32'h1000_0010, 32'hA000_0001, 32'h1000_0008, 1, 0));
    vecs.push_back(mk("brMisal",  0, 0, 0, 1, 32'h1000_0102, 0, 26'h0,        0, 32'h0,         32'h1000_0100, 32'hA000_0004, 32'h1000_0014, 1, 1));

    // Rows up to the misaligned jr, then the sticky-flag run, then the rest.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    // AddrError must persist across free-running cycles until reset.
    reset = 1'b0; bus.Stall = 1'b0; bus.Flush = 1'b0; bus.BranchTaken = 1'b0;
    bus.Jump = 1'b0; bus.JumpReg = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      nApplied++;
      compare($sformatf("sticky%0d.AddrError", k), {31'd0, bus.AddrError}, 32'd1);
      compare($sformatf("sticky%0d.PC", k), bus.PC, 32'h0040_0010 + 32'(4 * k));
    end

    for (int i = 14; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule
